// File: rtl/data_bus_arbiter_pkg.sv
// Shared size codes, arbiter state encodings and the latched-request layout
// used by the data-bus arbiter and its round-robin grant logic.
package data_bus_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Illegal size code or an address not naturally aligned to the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr[0];
      SIZE_WORD: return addr[1:0] != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 32'h0000_00ff;
      SIZE_HALF: return 32'h0000_ffff;
      default:   return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserting requester searching
// upward from last_grant+1 with wrap, as one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Scan farthest to nearest so the nearest asserting requester is kept.
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IW'((int'(last_grant) + off) % N_REQ);
      if (req[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    grant[grant_idx] = grant_any;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin front end for the shared data-bus controller: one transaction
// in flight, size/alignment screened at accept, one response per request.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int RD_LATENCY   = 1,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [2*N_REQ-1:0]    req_size,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_wd,
  output logic                  bus_rd,
  output logic [1:0]            bus_size_in,
  output logic [1:0]            bus_size_out,
  output logic [31:0]           bus_addr_in,
  output logic [31:0]           bus_addr_out,
  output logic [31:0]           bus_data_in,
  input  logic [31:0]           bus_data_out,
  input  logic                  bus_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]       state_reg;
  logic [IW-1:0]    last_grant_reg;
  logic [IW-1:0]    grant_reg;
  bus_req_t         lat_reg;
  logic [LW-1:0]    lat_cnt_reg;
  logic [TW-1:0]    tmo_cnt_reg;
  logic             err_reg;
  logic [31:0]      rdata_reg;

  bus_req_t         req_fields [N_REQ];
  bus_req_t         sel_req;
  logic [N_REQ-1:0] grant_onehot;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic             accept_en;
  logic             accept;
  logic             in_issue;
  logic             in_wait;
  logic             in_resp;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_fields[gi] = {req_we[gi], req_size[2*gi +: 2],
                               req_addr[32*gi +: 32], req_wdata[32*gi +: 32]};
      assign rsp_valid[gi]  = in_resp && (grant_reg == IW'(gi));
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant_onehot),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Ready is offered only from IDLE with the controller free and out of reset.
  assign accept_en = rst && (state_reg == ARB_IDLE) && !bus_busy;
  assign req_ready = accept_en ? grant_onehot : '0;
  assign accept    = accept_en && grant_any;
  assign sel_req   = req_fields[grant_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= IW'(N_REQ - 1);
      grant_reg      <= '0;
      lat_reg        <= '0;
      lat_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (accept) begin
            lat_reg     <= sel_req;
            grant_reg   <= grant_idx;
            rdata_reg   <= '0;
            tmo_cnt_reg <= '0;
            err_reg     <= access_err(sel_req.size, sel_req.addr);
            state_reg   <= access_err(sel_req.size, sel_req.addr) ? ARB_RESP : ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (lat_reg.we) begin
            state_reg <= ARB_RESP;
          end else begin
            lat_cnt_reg <= LW'(RD_LATENCY);
            state_reg   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus_busy) begin
            if (tmo_cnt_reg == TW'(BUSY_TIMEOUT - 1)) begin
              err_reg   <= 1'b1;
              rdata_reg <= '0;
              state_reg <= ARB_RESP;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            end
          end else begin
            tmo_cnt_reg <= '0;
            if (lat_cnt_reg == LW'(1)) begin
              rdata_reg <= bus_data_out & size_mask(lat_reg.size);
              state_reg <= ARB_RESP;
            end else begin
              lat_cnt_reg <= lat_cnt_reg - LW'(1);
            end
          end
        end
        default: begin
          last_grant_reg <= grant_reg;
          state_reg      <= ARB_IDLE;
        end
      endcase
    end
  end

  assign in_issue = (state_reg == ARB_ISSUE);
  assign in_wait  = (state_reg == ARB_WAIT);
  assign in_resp  = (state_reg == ARB_RESP);

  assign bus_wd       = in_issue && lat_reg.we;
  assign bus_rd       = (in_issue || in_wait) && !lat_reg.we;
  assign bus_addr_in  = bus_wd ? lat_reg.addr  : '0;
  assign bus_size_in  = bus_wd ? lat_reg.size  : '0;
  assign bus_data_in  = bus_wd ? lat_reg.wdata : '0;
  assign bus_addr_out = bus_rd ? lat_reg.addr  : '0;
  assign bus_size_out = bus_rd ? lat_reg.size  : '0;

  assign rsp_err   = in_resp && err_reg;
  assign rsp_rdata = in_resp ? rdata_reg : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: queued requests per requester, a byte-array
// controller model, and a transaction-level reference checked every cycle.
module tb_data_bus_arbiter;

  localparam int N_REQ        = 2;
  localparam int RD_LATENCY   = 1;
  localparam int BUSY_TIMEOUT = 15;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        busy_k;
    int        rst_off;
  } txn_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_we = '0;
  logic [2*N_REQ-1:0]  req_size = '0;
  logic [32*N_REQ-1:0] req_addr = '0;
  logic [32*N_REQ-1:0] req_wdata = '0;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                bus_wd, bus_rd;
  logic [1:0]          bus_size_in, bus_size_out;
  logic [31:0]         bus_addr_in, bus_addr_out, bus_data_in;
  logic [31:0]         bus_data_out;
  logic                bus_busy = 1'b0;
  logic                mem_clear = 1'b1;

  data_bus_arbiter #(.N_REQ(N_REQ), .RD_LATENCY(RD_LATENCY), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size_in(bus_size_in), .bus_size_out(bus_size_out),
    .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  // Controller model: little-endian byte store, registered read data.
  logic [7:0] ctl_mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < 256; k++) ctl_mem[k] <= 8'h00;
    end else begin
      if (bus_wd)
        for (int k = 0; k < 4; k++)
          if (k < (1 << bus_size_in)) ctl_mem[8'(bus_addr_in + 32'(k))] <= bus_data_in[8*k +: 8];
      if (bus_rd)
        bus_data_out <= {ctl_mem[8'(bus_addr_out + 32'd3)], ctl_mem[8'(bus_addr_out + 32'd2)],
                         ctl_mem[8'(bus_addr_out + 32'd1)], ctl_mem[8'(bus_addr_out)]};
    end
  end

  // Reference model state
  txn_t       q0[$];
  txn_t       q1[$];
  txn_t       cur [N_REQ];
  bit [N_REQ-1:0] take;
  bit [7:0]   ref_mem [256];
  int         cyc, checks, errors, ntxn;
  bit         m_busy, m_we, m_err, m_acc_err, rand_busy;
  bit [1:0]   m_size;
  bit [31:0]  m_addr, m_wdata, m_data;
  int         m_acc, m_resp, m_grant, m_last;
  int         rb_start, rb_end, rst_cyc, rst_hold, idle_busy_until;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int r, input bit we, input bit [1:0] size, input bit [31:0] addr,
                      input bit [31:0] wdata, input int busy_k, input int rst_off);
    txn_t t;
    t = '{we: we, size: size, addr: addr, wdata: wdata, busy_k: busy_k, rst_off: rst_off};
    if (r == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic load(input int r);
    txn_t t;
    bit   got;
    got = 1'b0;
    t   = '{default: 0};
    if (r == 0 && q0.size() > 0) begin t = q0.pop_front(); got = 1'b1; end
    else if (r == 1 && q1.size() > 0) begin t = q1.pop_front(); got = 1'b1; end
    cur[r]                 = t;
    take[r]                = !got;
    req_valid[r]           = got;
    req_we[r]              = t.we;
    req_size[2*r +: 2]     = t.size;
    req_addr[32*r +: 32]   = t.addr;
    req_wdata[32*r +: 32]  = t.wdata;
  endtask

  task automatic accept(input int r);
    txn_t t;
    int   nb;
    t         = cur[r];
    nb        = 1 << t.size;
    m_acc_err = (t.size == 2'd3) || ((t.addr % nb) != 0);
    m_err     = m_acc_err;
    m_we      = t.we;
    m_size    = t.size;
    m_addr    = t.addr;
    m_wdata   = t.wdata;
    m_acc     = cyc;
    m_grant   = r;
    m_busy    = 1'b1;
    m_data    = '0;
    take[r]   = 1'b1;
    if (m_acc_err) begin
      m_resp = cyc + 1;
    end else if (t.we) begin
      m_resp = cyc + 2;
      for (int k = 0; k < nb; k++) ref_mem[8'(t.addr + 32'(k))] = t.wdata[8*k +: 8];
    end else begin
      rb_start = cyc + 2;
      rb_end   = cyc + 1 + t.busy_k;
      if (t.busy_k >= BUSY_TIMEOUT) begin
        m_resp = cyc + 2 + BUSY_TIMEOUT;
        m_err  = 1'b1;
      end else begin
        m_resp = cyc + RD_LATENCY + 2 + t.busy_k;
        for (int k = 0; k < nb; k++) m_data = m_data | (32'(ref_mem[8'(t.addr + 32'(k))]) << (8*k));
      end
    end
    rst_cyc = (t.rst_off > 0) ? cyc + t.rst_off : -1;
  endtask

  task automatic step();
    bit [N_REQ-1:0] exp_ready;
    bit             wd_e, rd_e, resp_e;
    int             idx;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) if (take[i]) load(i);
    rst       = (cyc < rst_hold || cyc == rst_cyc) ? 1'b0 : 1'b1;
    mem_clear = (cyc < rst_hold);
    bus_busy  = (cyc >= rb_start && cyc <= rb_end) || (cyc < idle_busy_until) ||
                (rand_busy && !m_busy && ($urandom_range(0, 3) == 0));
    #1;
    if (rst) begin
      exp_ready = '0;
      if (!m_busy && !bus_busy)
        for (int k = 1; k <= N_REQ; k++) begin
          idx = (m_last + k) % N_REQ;
          if (exp_ready == '0 && req_valid[idx]) exp_ready[idx] = 1'b1;
        end
      wd_e   = m_busy && !m_acc_err && m_we && (cyc == m_acc + 1);
      rd_e   = m_busy && !m_acc_err && !m_we && (cyc > m_acc) && (cyc < m_resp);
      resp_e = m_busy && (cyc == m_resp);
      check("req_ready",    32'(req_ready),    32'(exp_ready));
      check("rsp_valid",    32'(rsp_valid),    resp_e ? 32'(1 << m_grant) : 32'd0);
      check("rsp_err",      32'(rsp_err),      32'(resp_e && m_err));
      check("rsp_rdata",    rsp_rdata,         resp_e ? m_data : 32'd0);
      check("bus_wd",       32'(bus_wd),       32'(wd_e));
      check("bus_addr_in",  bus_addr_in,       wd_e ? m_addr : 32'd0);
      check("bus_size_in",  32'(bus_size_in),  wd_e ? 32'(m_size) : 32'd0);
      check("bus_data_in",  bus_data_in,       wd_e ? m_wdata : 32'd0);
      check("bus_rd",       32'(bus_rd),       32'(rd_e));
      check("bus_addr_out", bus_addr_out,      rd_e ? m_addr : 32'd0);
      check("bus_size_out", 32'(bus_size_out), rd_e ? 32'(m_size) : 32'd0);
      if (resp_e) begin
        $display("txn %0d: req%0d %s size=%0d addr=%08h err=%0d rdata=%08h latency=%0d",
                 ntxn, m_grant, m_we ? "wr" : "rd", m_size, m_addr, m_err, rsp_rdata, m_resp - m_acc);
        ntxn++;
        m_last = m_grant;
        m_busy = 1'b0;
      end
      for (int i = 0; i < N_REQ; i++) if (exp_ready[i]) accept(i);
    end else begin
      m_busy  = 1'b0;
      m_last  = N_REQ - 1;
      rb_end  = -1;
      rst_cyc = -1;
    end
    cyc++;
  endtask

  task automatic run(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req_valid != '0 || m_busy) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain", 32'(n < max_cyc), 32'd1);
    step();
  endtask

  initial begin
    bit        we;
    bit [1:0]  size;
    bit [31:0] addr;
    int        bk;
    int        busy_pick [6] = '{0, 0, 1, 2, 4, 15};
    checks = 0; errors = 0; cyc = 0; ntxn = 0;
    m_busy = 1'b0; m_last = N_REQ - 1; m_acc_err = 1'b0;
    rb_start = 0; rb_end = -1; rst_cyc = -1; rst_hold = 3;
    idle_busy_until = 0; rand_busy = 1'b0; take = '1;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;

    repeat (5) step();

    push(0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    run(20);
    push(1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 0);
    run(20);

    // Both requesters continuously valid: rotation 0,1,0,1
    push(0, 1'b1, 2'd2, 32'h40,  32'h1111_2222, 0, 0);
    push(0, 1'b0, 2'd2, 32'h40,  32'h0, 0, 0);
    push(1, 1'b1, 2'd1, 32'h82,  32'h3333_4444, 0, 0);
    push(1, 1'b0, 2'd0, 32'h101, 32'h0, 0, 0);
    run(40);

    push(0, 1'b1, 2'd1, 32'h101, 32'h5555_6666, 0, 0);
    push(0, 1'b0, 2'd2, 32'h102, 32'h0, 0, 0);
    push(0, 1'(($urandom_range(0, 1))), 2'd3, 32'h200, 32'h7777_8888, 0, 0);
    run(20);

    idle_busy_until = cyc + 4;
    push(1, 1'b1, 2'd0, 32'h33, 32'h0000_00AB, 0, 0);
    run(20);

    push(0, 1'b0, 2'd2, 32'h100, 32'h0, BUSY_TIMEOUT, 0);
    push(0, 1'b0, 2'd2, 32'h100, 32'h0, 3, 0);
    run(60);

    // Reset lands in WAIT; the aborted read must not answer
    push(0, 1'b0, 2'd2, 32'h40, 32'h0, 5, 3);
    run(30);
    push(1, 1'b1, 2'd2, 32'h44, 32'hCAFE_0001, 0, 0);
    push(0, 1'b1, 2'd2, 32'h48, 32'hCAFE_0000, 0, 0);
    run(20);

    rand_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      bk   = busy_pick[$urandom_range(0, 5)];
      push(int'($urandom_range(0, 1)), we, size, addr, $urandom, we ? 0 : bk, 0);
    end
    run(2500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
